ob_drain: RTL and testbench

Output-buffer drain engine that sits directly downstream of `matrix_mult_wrapper_03`. After a matrix multiply completes, it reads a programmed range of rows from the output buffer memory. Each `COL*WIDTH`-bit row is serialized into `DRIVER_WIDTH`-bit beats on a valid/ready stream toward the chip driver pins. It takes over the output memory port while the wrapper is idle; the port mux is external to this block.

---
 rtl/matrix_mult_pkg.sv | 21 ++
 rtl/ob_drain.sv | 136 +++++++++++++
 tb/tb_ob_drain.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mult_pkg.sv
// Shared constants and types for the matrix-multiply output path.
// The drain engine takes its beat geometry and drain FSM encoding from here.
package matrix_mult_pkg;

   localparam int MM_WIDTH        = 8;
   localparam int MM_COL          = 4;
   localparam int MM_O_SIZE       = 64;
   localparam int MM_DRIVER_WIDTH = 8;

   // Driver beats needed to move one output row off chip
   localparam int DRAIN_BEATS = (MM_COL * MM_WIDTH) / MM_DRIVER_WIDTH;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      CAPT = 3'd2,
      SEND = 3'd3,
      DONE = 3'd4
   } drain_state_e;

endpackage

// File: rtl/ob_drain.sv
// Output-buffer drain engine: reads a range of rows from the output buffer
// after a multiply finishes and serializes each row, lowest lane first,
// into DRIVER_WIDTH-bit beats on a valid/ready stream.
module ob_drain
   import matrix_mult_pkg::*;
#(
   parameter int WIDTH        = MM_WIDTH,
   parameter int COL          = MM_COL,
   parameter int O_SIZE       = MM_O_SIZE,
   parameter int DRIVER_WIDTH = MM_DRIVER_WIDTH
) (
   input  logic                        clk_i,
   input  logic                        rst_sync_i,
   input  logic                        start_i,
   input  logic [$clog2(O_SIZE)-1:0]   base_addr_i,
   input  logic [$clog2(O_SIZE):0]     num_rows_i,
   output logic                        mem_cenb_o,
   output logic                        mem_wenb_o,
   output logic [$clog2(O_SIZE)-1:0]   mem_addr_o,
   input  logic [COL*WIDTH-1:0]        mem_data_i,
   output logic [DRIVER_WIDTH-1:0]     data_o,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic                        busy_o,
   output logic                        done_o
);

   localparam int ROW_W = COL * WIDTH;
   localparam int BEATS = ROW_W / DRIVER_WIDTH;
   localparam int AW    = $clog2(O_SIZE);
   localparam int RW    = AW + 1;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   generate
      if ((ROW_W % DRIVER_WIDTH) != 0) begin : g_bad_beat_width
         $error("ob_drain: COL*WIDTH must be a multiple of DRIVER_WIDTH");
      end
   endgenerate

   // Row address advance, wrapping at the buffer depth even when it is not a power of two
   function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
      if (a == AW'(O_SIZE - 1)) begin
         return '0;
      end
      return a + AW'(1);
   endfunction

   drain_state_e          state_q;
   drain_state_e          state_d;
   logic [AW-1:0]         addr_q;
   logic [RW-1:0]         rows_q;
   logic [BW-1:0]         beat_q;
   logic [ROW_W-1:0]      shreg_q;
   logic                  last_beat;
   logic                  xfer;

   assign xfer      = (state_q == SEND) && ready_i;
   assign last_beat = (beat_q == BW'(BEATS - 1));

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_sync_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: one read, one capture cycle, then BEATS handshakes per row
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = (num_rows_i != '0) ? READ : DONE;
            end
         end
         READ:    state_d = CAPT;
         CAPT:    state_d = SEND;
         SEND: begin
            if (xfer && last_beat) begin
               state_d = (rows_q == RW'(1)) ? DONE : READ;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address, row count, beat count and shift register updates
   always_ff @(posedge clk_i) begin
      if (rst_sync_i) begin
         addr_q  <= '0;
         rows_q  <= '0;
         beat_q  <= '0;
         shreg_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i && (num_rows_i != '0)) begin
                  addr_q <= base_addr_i;
                  rows_q <= num_rows_i;
               end
            end
            CAPT: begin
               shreg_q <= mem_data_i;
               beat_q  <= '0;
            end
            SEND: begin
               if (ready_i) begin
                  shreg_q <= shreg_q >> DRIVER_WIDTH;
                  beat_q  <= beat_q + BW'(1);
                  if (last_beat) begin
                     rows_q <= rows_q - RW'(1);
                     addr_q <= addr_inc(addr_q);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decode straight from registers only; no input reaches an output combinationally
   always_comb begin
      mem_cenb_o = (state_q != READ);
      mem_addr_o = addr_q;
      data_o     = shreg_q[DRIVER_WIDTH-1:0];
      valid_o    = (state_q == SEND);
      busy_o     = (state_q != IDLE);
      done_o     = (state_q == DONE);
   end

   assign mem_wenb_o = 1'b1;

endmodule

// File: tb/tb_ob_drain.sv
// Directed bench for ob_drain: a behavioural output buffer, a negedge monitor
// that logs beats and reads, and a scoreboard of expected beats/addresses.
module tb_ob_drain;

   localparam int WIDTH  = 8;
   localparam int COL    = 4;
   localparam int O_SIZE = 64;
   localparam int DW     = 8;
   localparam int NBEAT  = COL * WIDTH / DW;

   logic              clk_i;
   logic              rst_sync_i;
   logic              start_i;
   logic [5:0]        base_addr_i;
   logic [6:0]        num_rows_i;
   logic              mem_cenb_o;
   logic              mem_wenb_o;
   logic [5:0]        mem_addr_o;
   logic [31:0]       mem_data_i;
   logic [7:0]        data_o;
   logic              valid_o;
   logic              ready_i;
   logic              busy_o;
   logic              done_o;

   ob_drain #(
      .WIDTH(WIDTH), .COL(COL), .O_SIZE(O_SIZE), .DRIVER_WIDTH(DW)
   ) dut (
      .clk_i       (clk_i),
      .rst_sync_i  (rst_sync_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .num_rows_i  (num_rows_i),
      .mem_cenb_o  (mem_cenb_o),
      .mem_wenb_o  (mem_wenb_o),
      .mem_addr_o  (mem_addr_o),
      .mem_data_i  (mem_data_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic [31:0] mem [0:63];

   // Output buffer model: one-cycle read latency
   always @(posedge clk_i) begin
      if (!mem_cenb_o) mem_data_i <= mem[mem_addr_o];
   end

   logic [7:0] obs_data [0:255];
   logic [5:0] rd_addr  [0:255];
   int obs_cnt   = 0;
   int rd_cnt    = 0;
   int done_cnt  = 0;
   int valid_cnt = 0;
   int stall_err = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = '0;

   // Monitor: values at negedge are what the next rising edge will act on
   always @(negedge clk_i) begin
      if (rst_sync_i) begin
         prev_stall <= 1'b0;
      end else begin
         if (valid_o && ready_i && obs_cnt < 256) begin
            obs_data[obs_cnt] <= data_o;
            obs_cnt <= obs_cnt + 1;
         end
         if (!mem_cenb_o && rd_cnt < 256) begin
            rd_addr[rd_cnt] <= mem_addr_o;
            rd_cnt <= rd_cnt + 1;
         end
         if (done_o)  done_cnt  <= done_cnt + 1;
         if (valid_o) valid_cnt <= valid_cnt + 1;
         if (prev_stall && (!valid_o || data_o !== prev_data)) stall_err <= stall_err + 1;
         prev_stall <= valid_o && !ready_i;
         prev_data  <= data_o;
      end
   end

   int tests = 0;
   int fails = 0;
   logic [7:0] exp_q  [$];
   logic [5:0] exp_rd [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cenb"},  mem_cenb_o, 1);
      check({tag, "_wenb"},  mem_wenb_o, 1);
      check({tag, "_addr"},  mem_addr_o, 0);
      check({tag, "_data"},  data_o,     0);
      check({tag, "_valid"}, valid_o,    0);
      check({tag, "_busy"},  busy_o,     0);
      check({tag, "_done"},  done_o,     0);
   endtask

   task automatic push_row(input int a, input int nb);
      exp_rd.push_back(a[5:0]);
      for (int b = 0; b < nb; b++) exp_q.push_back(mem[a][8*b +: 8]);
   endtask

   // Pop the scoreboard against everything the monitor logged since the snapshots
   task automatic score(input string tag, input int obs0, input int rd0, input int nbeats, input int nrows);
      for (int i = obs0; i < obs_cnt; i++) begin
         if (exp_q.size() == 0) check({tag, "_extra_beat"}, obs_data[i], 'x);
         else check({tag, "_beat"}, obs_data[i], exp_q.pop_front());
      end
      for (int i = rd0; i < rd_cnt; i++) begin
         if (exp_rd.size() == 0) check({tag, "_extra_read"}, rd_addr[i], 'x);
         else check({tag, "_rdaddr"}, rd_addr[i], exp_rd.pop_front());
      end
      check({tag, "_nbeats"}, obs_cnt - obs0, nbeats);
      check({tag, "_nreads"}, rd_cnt - rd0, nrows);
      exp_q.delete();
      exp_rd.delete();
   endtask

   task automatic run_drain(input string tag, input int base, input int n,
                            input bit bp, input bit busy_start);
      int obs0, rd0, dn0, st0, v0, lat, k;
      bit [3:0] pat;
      pat = 4'b1001;
      for (int r = 0; r < n; r++) push_row((base + r) % O_SIZE, NBEAT);
      obs0 = obs_cnt; rd0 = rd_cnt; dn0 = done_cnt; st0 = stall_err; v0 = valid_cnt;
      k = 0;
      start_i = 1'b1; base_addr_i = base[5:0]; num_rows_i = n[6:0];
      tick;
      start_i = 1'b0;
      if (bp) begin ready_i = pat[k % 4]; k++; end
      lat = 0;
      while (!done_o && lat < 300) begin
         tick;
         lat++;
         if (bp) begin ready_i = pat[k % 4]; k++; end
         if (busy_start && lat == 3) begin
            start_i = 1'b1; base_addr_i = 6'd40; num_rows_i = 7'd5;
         end
         if (busy_start && lat == 4) start_i = 1'b0;
      end
      check({tag, "_done_seen"}, done_o, 1);
      if (!bp) check({tag, "_latency"}, lat, n * (NBEAT + 2));
      ready_i = 1'b1;
      tick;
      check({tag, "_done_pulse"}, done_o, 0);
      check({tag, "_busy_low"}, busy_o, 0);
      check({tag, "_done_count"}, done_cnt - dn0, 1);
      check({tag, "_stall_stable"}, stall_err - st0, 0);
      if (n == 0) check({tag, "_no_valid"}, valid_cnt - v0, 0);
      score(tag, obs0, rd0, n * NBEAT, n);
   endtask

   initial begin
      int obs0, rd0, dn0;
      rst_sync_i = 1'b1; start_i = 1'b0; ready_i = 1'b1;
      base_addr_i = '0; num_rows_i = '0;
      for (int i = 0; i < O_SIZE; i++) mem[i] = $urandom;
      mem[5] = 32'h44332211;

      repeat (3) tick;
      check_reset_outputs("reset");
      rst_sync_i = 1'b0;
      tick;

      run_drain("single", 5, 1, 1'b0, 1'b0);
      run_drain("wrap", 62, 3, 1'b0, 1'b0);
      run_drain("bpress", 30, 2, 1'b1, 1'b0);
      run_drain("zero", 7, 0, 1'b0, 1'b0);
      run_drain("busystart", 10, 2, 1'b0, 1'b1);

      // Reset lands on the edge that would transfer beat 2 of the row
      push_row(20, 2);
      obs0 = obs_cnt; rd0 = rd_cnt; dn0 = done_cnt;
      start_i = 1'b1; base_addr_i = 6'd20; num_rows_i = 7'd1;
      tick;
      start_i = 1'b0;
      repeat (4) tick;
      rst_sync_i = 1'b1;
      tick;
      check_reset_outputs("midrst");
      rst_sync_i = 1'b0;
      repeat (4) tick;
      check("midrst_no_done", done_cnt - dn0, 0);
      check("midrst_idle", busy_o, 0);
      score("midrst", obs0, rd0, 2, 1);

      run_drain("fresh", 20, 1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
